serial_paralelo_rx_align: RTL
=============================

# serial_paralelo_rx_align

Parametrised serial-to-parallel receiver with comma-based word alignment and lock tracking. It deserialises a one-bit-per-cycle stream on clk_4f into DATA_W-bit words and searches every bit offset for the COMMA pattern. It declares lock after LOCK_COUNT consecutive aligned commas and drops lock after LOSS_COUNT misaligned commas. It sits at the RX front end, between the serial line and the RX demux/FIFO stage.

## Interface
- DATA_W, 8, word width in bits (≥4)
- COMMA, 8'hBC, DATA_W-bit alignment/idle pattern
- LOCK_COUNT, 4, consecutive aligned commas required to lock (≥1)
- LOSS_COUNT, 2, misaligned commas while locked that force loss of lock (≥1)

- clk_4f  in  1  clock; one serial bit sampled per rising edge
- reset  in  1  synchronous, active-low; has priority over all other logic
- data_in  in  1  serial data, MSB of each word first
- data_out  out  DATA_W  last received data word
- valid_out  out  1  one-cycle strobe, high when data_out is updated with a data word
- active_out  out  1  high while in LOCKED
- lock_loss_cnt  out  8  present only with SPRX_LOSS_CNT_EN

## Operation
- Shift register sr: sr <= {sr[DATA_W-2:0], data_in}. The window w = {sr[DATA_W-2:0], data_in} is the word that includes the current bit.
- bit_cnt counts modulo DATA_W. word_end = (bit_cnt == DATA_W-1).
- State machine with states HUNT, SYNC and LOCKED. Reset state is HUNT.
- HUNT: on any cycle with w == COMMA:
  - bit_cnt <= 0, comma_cnt <= 1.
  - If LOCK_COUNT == 1, go to LOCKED; otherwise go to SYNC.
- SYNC: only word_end cycles are evaluated.
  - w == COMMA: comma_cnt increments. When it reaches LOCK_COUNT, go to LOCKED, set active_out <= 1 and clear miss_cnt.
  - w != COMMA: go to HUNT and clear comma_cnt.
- LOCKED, word_end cycle:
  - w == COMMA: idle word. valid_out stays 0, data_out holds, miss_cnt <= 0.
  - Otherwise: data_out <= w, valid_out <= 1.
- LOCKED, non-word_end cycle with w == COMMA: this is a misaligned comma, and miss_cnt increments. When it reaches LOSS_COUNT:
  - go to HUNT;
  - active_out <= 0, valid_out <= 0, comma_cnt <= 0;
  - data_out holds its last value.
- valid_out defaults to 0 every cycle that does not explicitly set it.
- Arithmetic: comma_cnt and miss_cnt use $clog2(max+1) bits and never exceed their limits. bit_cnt wraps from DATA_W-1 to 0.

## Timing
- Reset values: data_out = 0, valid_out = 0, active_out = 0, lock_loss_cnt = 0. Internally state = HUNT, sr = 0, bit_cnt = 0, counters = 0.
- Reset mid-word or while locked: all outputs read reset values on the first edge with reset = 0. Alignment restarts from HUNT.
- Lock latency: active_out is 1 after the edge that samples the last bit of the LOCK_COUNT-th aligned comma.
- Data latency: data_out and valid_out update on the edge that samples a word's last bit, so they are visible one cycle after that bit is presented. valid_out is high for exactly 1 cycle per data word; the maximum strobe rate is 1 per DATA_W cycles.
- Unlock latency: active_out is 0 after the edge that samples the last bit of the LOSS_COUNT-th misaligned comma.
- Simultaneous events:
  - A HUNT comma match and a reset in the same cycle: reset wins.
  - Both a word_end and a misaligned match cannot occur in the same cycle, since they are mutually exclusive by definition.

## Configuration
- SPRX_LOSS_CNT_EN defined:
  - Port lock_loss_cnt[7:0] exists.
  - It increments on each LOCKED→HUNT transition and saturates at 8'hFF.
  - It clears only on reset.
- SPRX_LOSS_CNT_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset = 0 for 3 cycles with random data_in -> data_out = 0x00, valid_out = 0, active_out = 0 throughout.
- Lock and receive: send BC×4, then A5, 3C -> active_out rises after the 32nd bit. valid_out pulses with data_out = A5, then 3C. Each pulse is 1 cycle, and the pulses are 8 cycles apart.
- Interrupted sync: send BC×3, 55, then BC×4, 7E -> active_out stays 0 through 55. It rises after the next 4 commas, then data_out = 7E with one valid_out pulse.
- Bit slip: while locked, insert 3 extra bits, then send BC×2 -> active_out drops after the second misaligned BC. Re-lock occurs after 4 commas at the new offset. With the macro, lock_loss_cnt = 1.
- Reset mid-operation: assert reset 3 bits into a data word while locked -> outputs are 0 on the next edge, and no stale valid_out is emitted.
- Generalisation: DATA_W = 10, COMMA = 10'h17C, LOCK_COUNT = 2. Send 17C×2, then 2A5 -> lock after 20 bits, then data_out = 10'h2A5 with valid_out high for 1 cycle.

Source files
------------

// File: rtl/serial_paralelo_rx_align_if.sv
// Serial RX bus: serial line in, aligned parallel word, strobe and lock status out.
// lock_loss_cnt is carried only when SPRX_LOSS_CNT_EN is defined.
interface serial_paralelo_rx_align_if #(
    parameter int DATA_W = 8
);
    logic              data_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              active_out;
`ifdef SPRX_LOSS_CNT_EN
    logic [7:0]        lock_loss_cnt;

    modport master (output data_in, input data_out, valid_out, active_out, lock_loss_cnt);
    modport slave  (input data_in, output data_out, valid_out, active_out, lock_loss_cnt);
`else
    modport master (output data_in, input data_out, valid_out, active_out);
    modport slave  (input data_in, output data_out, valid_out, active_out);
`endif
endinterface

// File: rtl/serial_paralelo_rx_align.sv
// Serial-to-parallel receiver with comma word alignment and lock tracking (HUNT/SYNC/LOCKED).
// Optional lock-loss counter output enabled by SPRX_LOSS_CNT_EN.
module serial_paralelo_rx_align #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] COMMA      = 8'hBC,
    parameter int                LOCK_COUNT = 4,
    parameter int                LOSS_COUNT = 2
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    serial_paralelo_rx_align_if.slave     rx
);
    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, win;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     comma_cnt_q, comma_cnt_d;
    logic [MW-1:0]     miss_cnt_q, miss_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              word_end, is_comma;
`ifdef SPRX_LOSS_CNT_EN
    logic [7:0]        loss_q, loss_d;
`endif

    // Window includes the bit being sampled this cycle
    assign win      = {sr_q[DATA_W-2:0], rx.data_in};
    assign is_comma = (win == COMMA);
    assign word_end = (bit_cnt_q == BW'(DATA_W - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = word_end ? '0 : bit_cnt_q + BW'(1);
        comma_cnt_d = comma_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
`ifdef SPRX_LOSS_CNT_EN
        loss_d      = loss_q;
`endif
        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = CW'(1);
                    miss_cnt_d  = '0;
                    state_d     = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (word_end) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + CW'(1);
                        if (comma_cnt_q == CW'(LOCK_COUNT - 1)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d     = HUNT;
                        comma_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (word_end) begin
                    if (is_comma) begin
                        miss_cnt_d = '0;
                    end else begin
                        data_d  = win;
                        valid_d = 1'b1;
                    end
                end else if (is_comma) begin
                    miss_cnt_d = miss_cnt_q + MW'(1);
                    if (miss_cnt_q == MW'(LOSS_COUNT - 1)) begin
                        state_d     = HUNT;
                        comma_cnt_d = '0;
`ifdef SPRX_LOSS_CNT_EN
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
`ifdef SPRX_LOSS_CNT_EN
            loss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= win;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
`ifdef SPRX_LOSS_CNT_EN
            loss_q      <= loss_d;
`endif
        end
    end

    // active_out derives from the registered state so it tracks LOCKED exactly
    assign rx.data_out   = data_q;
    assign rx.valid_out  = valid_q;
    assign rx.active_out = (state_q == LOCKED);
`ifdef SPRX_LOSS_CNT_EN
    assign rx.lock_loss_cnt = loss_q;
`endif
endmodule
